// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered multi-stage reset release with optional per-stage ack, timeout and retry
module reset_sequencer #(
  parameter int unsigned Clk_Frequency  = 50_000_000,
  parameter int unsigned Num_Stages     = 4,
  parameter int unsigned Stage_Delay_us = 1000,
  parameter int unsigned Sync_Stages    = 2,
  parameter int unsigned Wait_Ack       = 0,
  parameter int unsigned Timeout_us     = 10000
) (
  input  logic                                ipClk,
  input  logic                                ipReset,
  input  logic                                ipSoftReset,
  input  logic [Num_Stages-1:0]               ipAck,
  output logic [Num_Stages-1:0]               opReset,
  output logic [$clog2(Num_Stages+1)-1:0]     opStage,
  output logic                                opDone,
  output logic                                opTimeout
);

  localparam int StW = $clog2(Num_Stages + 1);

  localparam logic [63:0] DelayRaw      = 64'(Clk_Frequency) * 64'(Stage_Delay_us) / 64'd1000000;
  localparam logic [63:0] TimeoutRaw    = 64'(Clk_Frequency) * 64'(Timeout_us) / 64'd1000000;
  localparam logic [63:0] DelayCycles   = (DelayRaw == 64'd0) ? 64'd1 : DelayRaw;
  localparam logic [63:0] TimeoutCycles = (TimeoutRaw == 64'd0) ? 64'd1 : TimeoutRaw;
  localparam logic [63:0] MaxCycles     = (DelayCycles > TimeoutCycles) ? DelayCycles : TimeoutCycles;
  localparam int          CntW          = $clog2(MaxCycles + 64'd1);

  localparam logic [CntW-1:0] DelayLast   = CntW'(DelayCycles - 64'd1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 64'd1);
  localparam logic [StW-1:0]  LastStage   = StW'(Num_Stages - 1);
  localparam logic [StW-1:0]  AllStages   = StW'(Num_Stages);

  typedef enum logic [1:0] {sReset, sDelay, sWaitAck, sDone} stateT;

  stateT                  state;
  logic [CntW-1:0]        count;
  logic [Sync_Stages-1:0] rstPipe;
  logic [Num_Stages-1:0]  ackMeta;
  logic [Num_Stages-1:0]  ackSync;
  logic [Num_Stages-1:0]  stageMask;
  logic                   ackHit;
  logic                   isLast;

  assign stageMask = Num_Stages'(1) << opStage;
  assign ackHit    = |(ackSync & stageMask);
  assign isLast    = (opStage == LastStage);

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      rstPipe <= '0;
      ackMeta <= '0;
      ackSync <= '0;
    end else begin
      rstPipe <= {rstPipe[Sync_Stages-2:0], 1'b1};
      ackMeta <= ipAck;
      ackSync <= ackMeta;
    end
  end

  // sReset behaves as DELAY(0) at count 0, so stage 0 counts from the first released edge
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      state     <= sReset;
      count     <= '0;
      opReset   <= '1;
      opStage   <= '0;
      opDone    <= 1'b0;
      opTimeout <= 1'b0;
    end else if (!rstPipe[Sync_Stages-1] || ipSoftReset) begin
      state   <= rstPipe[Sync_Stages-1] ? sDelay : sReset;
      count   <= '0;
      opReset <= '1;
      opStage <= '0;
      opDone  <= 1'b0;
    end else begin
      case (state)
        sReset, sDelay: begin
          if (count == DelayLast) begin
            opReset <= opReset & ~stageMask;
            count   <= '0;
            if (Wait_Ack != 0) begin
              state <= sWaitAck;
            end else if (isLast) begin
              state   <= sDone;
              opStage <= AllStages;
              opDone  <= 1'b1;
            end else begin
              state   <= sDelay;
              opStage <= opStage + StW'(1);
            end
          end else begin
            count <= count + CntW'(1);
          end
        end
        sWaitAck: begin
          if (ackHit) begin
            count <= '0;
            if (isLast) begin
              state   <= sDone;
              opStage <= AllStages;
              opDone  <= 1'b1;
            end else begin
              state   <= sDelay;
              opStage <= opStage + StW'(1);
            end
          end else if (count == TimeoutLast) begin
            state     <= sDelay;
            count     <= '0;
            opReset   <= '1;
            opStage   <= '0;
            opTimeout <= 1'b1;
          end else begin
            count <= count + CntW'(1);
          end
        end
        sDone: begin
          count <= '0;
        end
        default: begin
          state <= sReset;
          count <= '0;
        end
      endcase
    end
  end

endmodule
